rca_serial_seq: RTL and testbench
=================================

// Module: rca_serial_seq
// PURPOSE
//  Bit-serial ripple-carry adder sequencer that drives the 3-bit full-adder code LUT.
//  Latches two WIDTH-bit operands and presents one {a_i,b_i,carry} address per cycle,
//    LSB first, consuming the LUT's 4-bit code.
//  Cross-checks each returned sum/carry pair against local gate logic, retries once on
//    mismatch, and reports a sticky per-operation fault.
//  Sits between the operand source and the result sink; the LUT is a combinational peer.
// PARAMETERS
//  WIDTH    8   operand/result width in bits (>=2)
//  IDX_W    3   width of fault_bit, = clog2(WIDTH)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  start      in   1        request; accepted only when busy=0
//  op_a       in   WIDTH    operand A, sampled on accepted start
//  op_b       in   WIDTH    operand B, sampled on accepted start
//  cin        in   1        carry-in, sampled on accepted start
//  lut_addr   out  3        {a_i, b_i, carry_q} to the LUT
//  lut_data   in   4        LUT code: [3]=sum, [2]=carry-out, [1:0]=check (ignored here)
//  busy       out  1        high from the cycle after accept until done
//  done       out  1        one-cycle pulse; sum/cout/fault valid in that cycle and held after
//  sum        out  WIDTH    result
//  cout       out  1        final carry
//  fault      out  1        >=1 bit mismatched on both attempts during the last operation
//  fault_bit  out  IDX_W    index of the first such bit (0 if fault=0)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, sum, cout, fault, fault_bit, lut_addr all 0.
//  FSM IDLE/RUN/RETRY/DONE. All outputs registered except lut_addr, which is a mux of registered state.
//  IDLE:
//   - start=1: latch op_a, op_b, cin into shift regs/carry_q; clear fault, fault_bit; bit index i=0.
//   - Go to RUN.
//  RUN (bit i):
//   - lut_addr = {a[i], b[i], carry_q}; lut_data is sampled in the same cycle.
//   - Local check: s_l = a^b^c; c_l = maj(a,b,c).
//   - Match ({lut_data[3],lut_data[2]}=={s_l,c_l}): write sum[i]=lut_data[3], carry_q=lut_data[2], i++.
//   - Mismatch: hold i and go to RETRY.
//  RETRY (same bit, same address):
//   - Match: use the LUT value.
//   - Mismatch again: use s_l/c_l; set fault=1, and fault_bit=i only if fault was 0.
//   - Then i++ and return to RUN.
//  After bit WIDTH-1 is written: cout=carry_q_next, go to DONE.
//  DONE: done=1 for exactly 1 cycle, busy=0, go to IDLE.
//   - start in this cycle is ignored.
//  Latency: fault-free, start accepted at edge N -> done high in cycle N+WIDTH+1.
//   - Each retried bit adds 1 cycle.
//  busy=1 in RUN/RETRY; start while busy is ignored.
//  Operands change after accept: no effect (latched).
//  lut_addr in IDLE/DONE = 3'b000.
//  Reset mid-operation: abort immediately, no done pulse, outputs return to reset values.
//  Arithmetic is unsigned modulo 2^WIDTH; overflow is reported only via cout.
// STRUCTURE
//  Shared package rca_pkg holds:
//   - state enum (S_IDLE, S_RUN, S_RETRY, S_DONE);
//   - LUT field indices LUT_SUM=3, LUT_CARRY=2.
//  Sub-module fa_check: combinational local sum/majority plus compare, outputs {s_l,c_l,match}.
//  The LUT is instantiated at the top level, beside this block, not inside it.
// TESTING
//  1. A=0xA5, B=0x3C, cin=0, good LUT -> done at cycle 9: sum=0xE1, cout=0, fault=0.
//  2. A=0xFF, B=0x01, cin=0 -> sum=0x00, cout=1; the carry ripples through all 8 bits.
//  3. A=0x00, B=0x00, cin=1 -> sum=0x01, cout=0; lut_addr sequence 001,000,...,000.
//  4. Bit 3 transient flip on first read only -> 1 extra cycle, done at cycle 10.
//     Correct sum, fault=0.
//  5. Stuck LUT data[3] at bit 2 and bit 5, A=0x0F, B=0x01 -> sum=0x10 via local fallback.
//     fault=1, fault_bit=2, done at cycle 11.
//  6. start again while busy: ignored. rst at cycle 4: busy=0, no done pulse.
//     Next start completes normally.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared definitions for the bit-serial ripple-carry sequencer: FSM states and LUT field positions.
package rca_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RETRY,
    S_DONE
  } state_t;

  localparam int unsigned LUT_SUM   = 3;
  localparam int unsigned LUT_CARRY = 2;

endpackage

// File: rtl/rca_serial_seq_fa_check.sv
// Local full-adder reference used to cross-check the sum/carry pair returned by the LUT.
module fa_check (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic lut_sum,
  input  logic lut_carry,
  output logic s_l,
  output logic c_l,
  output logic match
);

  always_comb begin
    s_l   = a ^ b ^ c;
    c_l   = (a & b) | (a & c) | (b & c);
    match = (lut_sum == s_l) && (lut_carry == c_l);
  end

endmodule

// File: rtl/rca_serial_seq.sv
// Bit-serial ripple-carry adder: walks the operands LSB first through an external full-adder LUT,
// retrying a bit once on disagreement with local logic and falling back to the local result.
module rca_serial_seq
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic [2:0]       lut_addr,
  input  logic [3:0]       lut_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fault,
  output logic [IDX_W-1:0] fault_bit
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;

  logic s_l, c_l, match;
  logic advance, use_lut, flag_fault, last;
  logic bit_sum, bit_carry;

  assign last = (idx_q == IDX_W'(WIDTH - 1));

  fa_check u_fa_check (
    .a         (a_q[0]),
    .b         (b_q[0]),
    .c         (carry_q),
    .lut_sum   (lut_data[LUT_SUM]),
    .lut_carry (lut_data[LUT_CARRY]),
    .s_l       (s_l),
    .c_l       (c_l),
    .match     (match)
  );

  // Operands are shifted right as bits retire, so bit 0 is always the current bit.
  always_comb begin
    lut_addr = '0;
    if (state_q == S_RUN || state_q == S_RETRY) begin
      lut_addr = {a_q[0], b_q[0], carry_q};
    end
  end

  always_comb begin
    state_d    = state_q;
    advance    = 1'b0;
    use_lut    = 1'b1;
    flag_fault = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (match) advance = 1'b1;
        else       state_d = S_RETRY;
      end
      S_RETRY: begin
        advance = 1'b1;
        state_d = S_RUN;
        if (!match) begin
          use_lut    = 1'b0;
          flag_fault = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance && last) state_d = S_DONE;
    bit_sum   = use_lut ? lut_data[LUT_SUM]   : s_l;
    bit_carry = use_lut ? lut_data[LUT_CARRY] : c_l;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      fault_bit <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == S_RUN) || (state_d == S_RETRY);
      done    <= (state_d == S_DONE);
      if (state_q == S_IDLE && start) begin
        a_q       <= op_a;
        b_q       <= op_b;
        carry_q   <= cin;
        idx_q     <= '0;
        fault     <= 1'b0;
        fault_bit <= '0;
      end
      if (advance) begin
        sum[idx_q] <= bit_sum;
        carry_q    <= bit_carry;
        a_q        <= a_q >> 1;
        b_q        <= b_q >> 1;
        idx_q      <= idx_q + IDX_W'(1);
        if (last) cout <= bit_carry;
      end
      // Only the first doubly-failed bit of an operation is recorded.
      if (flag_fault) begin
        fault <= 1'b1;
        if (!fault) fault_bit <= idx_q;
      end
    end
  end

endmodule

// File: tb/tb_rca_serial_seq.sv
// Randomized bench for rca_serial_seq with an arithmetic reference and a fault-injecting LUT model.
module tb_rca_serial_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         cin;
  logic [2:0]   lut_addr;
  logic [3:0]   lut_data;
  logic         busy, done, cout, fault;
  logic [W-1:0] sum;
  logic [2:0]   fault_bit;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Per-bit fault plan: 0 none, 1 wrong on first read only, 2 wrong on every read.
  int   ft[W];
  int   sched_bit[2*W];
  logic sched_flip[2*W];
  int   n_rd = 0;
  int   rd = 0;

  always #5 clk = ~clk;

  rca_serial_seq #(.WIDTH(W), .IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .fault     (fault),
    .fault_bit (fault_bit)
  );

  always_comb begin
    lut_data[3]   = ^lut_addr;
    lut_data[2]   = (lut_addr[2] & lut_addr[1]) | (lut_addr[2] & lut_addr[0]) | (lut_addr[1] & lut_addr[0]);
    lut_data[1:0] = lut_addr[1:0] ^ 2'b10;
    if (busy && rd < n_rd && sched_flip[rd]) lut_data[3] = ~lut_data[3];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < W; i++) ft[i] = 0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input bit poke);
    logic [W:0]  full;
    int          nf, fb, edges, bi;
    bit          seen, wb;
    int unsigned msk, cy;
    logic [2:0]  exp_addr;
    full = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
    n_rd = 0; nf = 0; fb = -1;
    for (int i = 0; i < W; i++) begin
      sched_bit[n_rd] = i; sched_flip[n_rd] = (ft[i] != 0); n_rd++;
      if (ft[i] != 0) begin
        sched_bit[n_rd] = i; sched_flip[n_rd] = (ft[i] == 2); n_rd++;
        nf++;
        if (ft[i] == 2 && fb < 0) fb = i;
      end
    end
    rd = 0;
    @(negedge clk);
    op_a = a; op_b = b; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
    edges = 0; seen = 0;
    while (!seen && edges <= 3*W + 4) begin
      @(negedge clk);
      wb = busy;
      if (done) seen = 1;
      else begin
        if (busy && rd < n_rd) begin
          bi  = sched_bit[rd];
          msk = (32'd1 << bi) - 1;
          cy  = ((32'(a) & msk) + (32'(b) & msk) + 32'(ci)) >> bi;
          exp_addr = {a[bi], b[bi], cy[0]};
          chk("lut_addr", 32'(lut_addr), 32'(exp_addr));
        end
        if (poke && edges == 2) begin
          start = 1'b1; op_a = ~a; op_b = ~b; cin = ~ci;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (wb) rd++;
        edges++;
      end
    end
    if (!seen) chk("done_timeout", 32'(0), 32'(1));
    else begin
      chk("latency",   32'(edges),     32'(W + nf));
      chk("sum",       32'(sum),       32'(full[W-1:0]));
      chk("cout",      32'(cout),      32'(full[W]));
      chk("fault",     32'(fault),     32'(fb >= 0));
      chk("fault_bit", 32'(fault_bit), (fb >= 0) ? 32'(fb) : 32'(0));
      chk("busy_in_done", 32'(busy), 32'(0));
      start = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'(0));
      chk("start_in_done_ignored", 32'(busy), 32'(0));
      chk("sum_held", 32'(sum), 32'(full[W-1:0]));
    end
    clear_faults();
  endtask

  initial begin
    int dcnt, r;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    clear_faults();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_fault", 32'(fault), 32'(0));
    chk("rst_fault_bit", 32'(fault_bit), 32'(0));
    chk("rst_lut_addr", 32'(lut_addr), 32'(0));
    rst = 1'b0;

    run_op(8'hA5, 8'h3C, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 1'b0);
    ft[3] = 1;
    run_op(8'hA5, 8'h3C, 1'b0, 1'b0);
    ft[2] = 2; ft[5] = 2;
    run_op(8'h0F, 8'h01, 1'b0, 1'b0);
    run_op(8'h5A, 8'hC3, 1'b1, 1'b1);

    // Abort mid-operation: reset returns every output to idle with no done pulse.
    n_rd = 0;
    @(negedge clk);
    op_a = 8'h77; op_b = 8'h19; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
    chk("abort_lut_addr", 32'(lut_addr), 32'(0));
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'(0));
    run_op(8'h77, 8'h19, 1'b1, 1'b0);

    repeat (40) begin
      for (int i = 0; i < W; i++) begin
        r = int'($urandom_range(0, 9));
        ft[i] = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      end
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
